// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory instruction port and its decode-side handshake.
// master = fetch unit, slave = memory plus decode.
interface fetch_unit_if;
    logic [31:0] pc_addr;
    logic        read_instr;
    logic [31:0] instr;
    logic        instr_ready;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output pc_addr, read_instr, if_valid, if_pc, if_instr,
        input  instr, instr_ready, if_ready
    );

    modport slave (
        input  pc_addr, read_instr, if_valid, if_pc, if_instr,
        output instr, instr_ready, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one outstanding memory request,
// an in-order {pc, instr} queue toward decode, and redirect handling with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

    state_t             state, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        target_q, target_d;
    logic               started;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        q_pc    [QUEUE_DEPTH];
    logic [31:0]        q_instr [QUEUE_DEPTH];
    logic               strobe, push, pop, head_valid;
    logic [31:0]        redir_aligned;

    assign redir_aligned = {redirect_pc[31:2], 2'b00};
    assign head_valid    = (count != '0);
    // A redirect voids any coincident pop: the whole queue is being flushed anyway.
    assign pop           = head_valid && bus.if_ready && !redirect;

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state;
        pc_d     = pc_q;
        target_d = target_q;
        strobe   = 1'b0;
        push     = 1'b0;
        case (state)
            ISSUE: begin
                // At most one request outstanding, so nothing is in flight while in ISSUE.
                strobe = started && (count < DEPTH_C);
                if (redirect) begin
                    if (strobe) begin
                        target_d = redir_aligned;
                        state_d  = DROP;
                    end else begin
                        pc_d = redir_aligned;
                    end
                end else if (strobe) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (bus.instr_ready) begin
                        pc_d    = redir_aligned;
                        state_d = ISSUE;
                    end else begin
                        target_d = redir_aligned;
                        state_d  = DROP;
                    end
                end else if (bus.instr_ready) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ISSUE;
                end
            end
            DROP: begin
                // pc_addr stays on the stale request until its response arrives.
                if (redirect) begin
                    if (bus.instr_ready) begin
                        pc_d    = redir_aligned;
                        state_d = ISSUE;
                    end else begin
                        target_d = redir_aligned;
                    end
                end else if (bus.instr_ready) begin
                    pc_d    = target_q;
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ISSUE;
            started  <= 1'b0;
            pc_q     <= RESET_PC;
            target_q <= '0;
        end else begin
            state    <= state_d;
            started  <= 1'b1;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; the if_* outputs are masked by if_valid,
    // so unwritten entries are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc_q;
            q_instr[wr_ptr] <= bus.instr;
        end
    end

    assign bus.pc_addr    = pc_q;
    assign bus.read_instr = strobe;
    assign bus.if_valid   = head_valid;
    assign bus.if_pc      = head_valid ? q_pc[rd_ptr]    : '0;
    assign bus.if_instr   = head_valid ? q_instr[rd_ptr] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers strobes, directed phases push the
// expected {pc, instr} stream, and a negedge monitor checks every item decode accepts.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        mem_rdy;
    logic        late_rdy;
    logic [31:0] mem_data;
    bit          mem_on;
    int          mem_lat;

    int passes     = 0;
    int checks     = 0;
    int accept_cnt = 0;
    int strobe_cnt = 0;
    int cyc        = 0;
    int acc_time[$];
    item_t exp_q[$];

    fetch_unit_if bus ();

    assign bus.instr_ready = mem_rdy | late_rdy;
    assign bus.instr       = late_rdy ? 32'hBAD0_BAD0 : mem_data;
    assign bus.if_ready    = dec_ready;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        item_t it;
        it.pc    = pc;
        it.instr = img(pc);
        exp_q.push_back(it);
    endtask

    // Memory: answers each strobe after mem_lat cycles with img(address).
    initial begin
        logic [31:0] req;
        mem_rdy  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_on && rst_n && bus.read_instr) begin
                req = bus.pc_addr;
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                check("pc_hold", bus.pc_addr, req);
                mem_rdy  = 1'b1;
                mem_data = img(req);
                @(posedge clk);
                #1;
                mem_rdy  = 1'b0;
                mem_data = '0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && bus.read_instr) strobe_cnt++;
    end

    // Monitor: an item counts as delivered when valid & ready with no redirect voiding the pop.
    initial forever begin
        item_t e;
        @(negedge clk);
        if (rst_n && bus.if_valid && bus.if_ready && !redirect) begin
            accept_cnt++;
            acc_time.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got pc %h instr %h, required no item",
                         bus.if_pc, bus.if_instr);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", bus.if_pc, e.pc);
                check("sb_instr", bus.if_instr, e.instr);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        int target = accept_cnt + n;
        int budget = 0;
        dec_ready = 1'b1;
        while (accept_cnt < target && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        dec_ready = 1'b0;
        check("drain_count", 32'(accept_cnt), 32'(target));
    endtask

    task automatic wait_strobe(output logic [31:0] pc);
        bit found = 1'b0;
        pc = 'x;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.read_instr) begin
                pc    = bus.pc_addr;
                found = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("strobe_seen", 32'(found), 32'd1);
    endtask

    task automatic do_reset(input bit late_pulse);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_pc_addr", bus.pc_addr, 32'h0000_0000);
        check("rst_read_instr", 32'(bus.read_instr), 32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (late_pulse) begin
            late_rdy = 1'b1;
            @(posedge clk);
            #1;
            late_rdy = 1'b0;
            check("late_if_valid", 32'(bus.if_valid), 32'd0);
            check("late_pc_addr", bus.pc_addr, 32'h0000_0000);
        end
    endtask

    initial begin
        logic [31:0] spc;
        bit hold_ok;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        late_rdy    = 1'b0;
        mem_on      = 1'b1;
        mem_lat     = 1;

        // Streaming at latency 1: one instruction every two cycles.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        acc_time.delete();
        drain(8);
        check("throughput", (acc_time.size() >= 8) ? 32'(acc_time[7] - acc_time[0])
                                                   : 32'hFFFF_FFFF, 32'd14);
        settle(10);

        // Decode stalled: exactly two strobes fill the queue, head holds pc 0.
        do_reset(1'b0);
        strobe_cnt = 0;
        hold_ok    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i >= 9)
                hold_ok &= bus.if_valid && (bus.if_pc == 32'd0) && (bus.if_instr == img(32'd0));
        end
        check("stall_strobes", 32'(strobe_cnt), 32'd2);
        check("stall_hold", 32'(hold_ok), 32'd1);
        check("stall_no_strobe", 32'(bus.read_instr), 32'd0);
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
        drain(3);
        settle(10);

        // Redirect while a latency-4 request is outstanding.
        mem_lat = 4;
        expect_pc(32'h0000_000C);
        drain(1);
        wait_strobe(spc);
        check("inflight_pc", spc, 32'h0000_0014);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_q.delete();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check("flush_valid", 32'(bus.if_valid), 32'd0);
        expect_pc(32'h0000_0100);
        expect_pc(32'h0000_0104);
        wait_strobe(spc);
        check("redir_strobe_pc", spc, 32'h0000_0100);
        drain(2);
        settle(20);

        // Redirect coincident with a response and a decode pop.
        mem_lat = 1;
        expect_pc(32'h0000_0108);
        drain(1);
        wait_strobe(spc);
        check("coinc_strobe_pc", spc, 32'h0000_0110);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        dec_ready   = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        dec_ready = 1'b0;
        check("coinc_flush_valid", 32'(bus.if_valid), 32'd0);
        expect_pc(32'h0000_0200);
        expect_pc(32'h0000_0204);
        drain(2);

        // Redirect near the top of the address space: PC wraps to zero.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        drain(3);
        settle(10);

        // Reset mid-WAIT, then a late response strobe that must be ignored.
        mem_on = 1'b0;
        expect_pc(32'h0000_0004);
        drain(1);
        wait_strobe(spc);
        check("wait_pc", spc, 32'h0000_000C);
        settle(2);
        do_reset(1'b1);
        mem_on = 1'b1;
        expect_pc(32'h0000_0000);
        drain(1);
        settle(5);

        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
